fifo_rd_burst_arb: RTL
======================

# fifo_rd_burst_arb

Read-side burst scheduler for the asynchronous FIFO, running entirely in the read clock domain. It shares the FIFO read port among NUM_REQ consumers with round-robin arbitration. For each granted consumer it drains a burst of up to MAX_BURST words by driving `rinc`. Each popped word is presented on a registered valid/ready output stream tagged with the consumer ID and an end-of-burst marker.

## Interface
- `DATA_SIZE`, 12: FIFO word width.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: largest burst length; `BURST_W` = $clog2(MAX_BURST+1).
- `TIMEOUT_CYC`, 255: starvation limit; used only with the timeout macro.
- `rclk` input 1: read clock.
- `rrst` input 1: reset, asynchronous, active-low; clock rclk.
- `rEmpty` input 1: FIFO empty flag, synchronous to rclk.
- `rData` input DATA_SIZE: FIFO head word, first-word-fall-through, valid whenever `rEmpty`=0.
- `rinc` output 1: pop strobe to the FIFO.
- `req` input NUM_REQ: per-consumer burst request, level.
- `req_len` input NUM_REQ*BURST_W: per-consumer burst length; slice i belongs to req[i].
- `gnt` output NUM_REQ: one-hot, single-cycle grant pulse.
- `out_valid` output 1: output word valid.
- `out_ready` input 1: downstream accept.
- `out_data` output DATA_SIZE: popped word.
- `out_id` output $clog2(NUM_REQ): owner of the current burst.
- `out_last` output 1: final word of the burst.
- `busy` output 1: FSM not in IDLE.

## Operation
- FSM states:
  - IDLE -> BURST when any eligible request exists. A request is eligible when req[i]=1 and req_len slice ≠ 0.
  - BURST -> IDLE when the word carrying `out_last` is accepted (`out_valid` & `out_ready`).
  - With the timeout macro: BURST -> IDLE on timeout.
- Arbitration: round-robin starting at pointer `rr_ptr`. The winner i latches `out_id`=i and `remaining`=min(req_len[i], MAX_BURST). After each burst completes, `rr_ptr` advances to i+1 mod NUM_REQ.
- `gnt[i]` pulses in the first BURST cycle. A consumer keeps `req` high only if it wants another burst.
- Pop: `rinc` = BURST & `remaining`≠0 & !`rEmpty` & (!`out_valid` | `out_ready`).
- On each pop:
  - `out_data` <= `rData`, `out_valid` <= 1, `remaining` decrements.
  - `out_last` <= (`remaining`==1).
- If the output is accepted with no pop in the same cycle, `out_valid` <= 0.
- Once raised, `out_valid` holds with stable `out_data`/`out_id`/`out_last` until accepted.
- FIFO empty mid-burst: stall with no pop; the burst stays owned and no other requester is granted.
- Reset values: `rinc`=0, `gnt`=0, `out_valid`=0, `out_data`=0, `out_id`=0, `out_last`=0, `busy`=0, `rr_ptr`=0, state IDLE.
- Reset mid-burst abandons the burst. Words already popped are lost.

## Timing
- Request seen in IDLE at edge N -> BURST from N; `gnt` is high during cycle N..N+1.
- First `rinc` can occur in the grant cycle. `out_valid` rises one cycle after each pop.
- Throughput is one word per cycle while `out_ready`=1 and the FIFO is non-empty.
- `rinc` depends combinationally on `out_ready` and `rEmpty`.
- Minimum one IDLE cycle between consecutive bursts.

## Configuration
- `FIFO_RD_BURST_ARB_TIMEOUT_EN` defined:
  - Adds output `timeout_err` (1 bit).
  - A counter runs while in BURST with `rEmpty`=1 and `remaining`≠0.
  - When the counter reaches TIMEOUT_CYC, the burst aborts: `timeout_err` pulses for 1 cycle, state returns to IDLE, and `rr_ptr` advances.
  - A pending output word is still delivered, with `out_last` unchanged.
- Undefined: no port and no counter. A stalled burst waits indefinitely.

## Structure
- Package `fifo_rd_arb_pkg` holds:
  - `state_e` (IDLE, BURST).
  - The `BURST_W` helper function.
- Sub-module `rr_arbiter`: combinational one-hot round-robin pick from the eligibility vector and `rr_ptr`.

## Test plan
- **Single burst:** req[1]=1, len=4, FIFO holds 10 words, `out_ready`=1 -> one `gnt`=0010 pulse, 4 consecutive `rinc`, `out_id`=1, `out_last` on word 4, `busy`=0 afterwards.
- **Round-robin:** req=1111, len=2 each -> grants in order 0,1,2,3,0. Each burst is 2 words with ≥1 idle cycle between bursts.
- **Backpressure:** `out_ready` toggles 1,0,0,1 during a 3-word burst -> `out_data` stable while stalled, no `rinc` while `out_valid`=1 & `out_ready`=0, all 3 words delivered in order.
- **Empty stall:** len=5 with only 2 words present, 3 more written 20 cycles later -> burst resumes, no other grant in between, exactly 5 words delivered.
- **Boundaries:** len=0 -> never granted. len=MAX_BURST+3 -> clamped to 16 words.
- **Reset/timeout:** rrst low mid-burst -> all outputs 0 asynchronously. With the macro and TIMEOUT_CYC=8 and the FIFO empty -> `timeout_err` pulses 8 cycles after the stall begins.

Source files
------------

// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-side burst scheduler.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Width needed to hold a burst length in 0..max_burst.
  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans the eligibility vector starting
// at i_ptr and returns the first eligible requester as one-hot plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic             w_found;
  logic [IDX_W-1:0] w_j;

  // Rotating priority scan; the first hit from i_ptr upward wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_elig[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  assign o_any = |i_elig;

endmodule

// File: rtl/fifo_rd_burst_arb.sv
// Read-side burst scheduler for the async FIFO (read clock domain only).
// Round-robin grants the FIFO read port to one consumer at a time and drains
// up to MAX_BURST words into a registered valid/ready stream tagged with the
// owner id and an end-of-burst marker.
// Optional: define FIFO_RD_BURST_ARB_TIMEOUT_EN to abort bursts that sit on
// an empty FIFO for TIMEOUT_CYC cycles (adds the timeout_err output).
module fifo_rd_burst_arb
  import fifo_rd_arb_pkg::*;
#(
  parameter  int DATA_SIZE   = 12,
  parameter  int NUM_REQ     = 4,
  parameter  int MAX_BURST   = 16,
  parameter  int TIMEOUT_CYC = 255,
  localparam int BURST_W     = burst_w(MAX_BURST),
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       rEmpty,
  input  logic [DATA_SIZE-1:0]       rData,
  output logic                       rinc,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_SIZE-1:0]       out_data,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_last,
`ifdef FIFO_RD_BURST_ARB_TIMEOUT_EN
  output logic                       timeout_err,
`endif
  output logic                       busy
);

  localparam logic [BURST_W-1:0] MAXB = BURST_W'(MAX_BURST);

  state_e               r_state;
  logic [BURST_W-1:0]   r_rem;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_out_id;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [DATA_SIZE-1:0] r_out_data;

  logic [BURST_W-1:0]   w_len [NUM_REQ];
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_pick;
  logic [ID_W-1:0]      w_pick_idx;
  logic                 w_any;
  logic [BURST_W-1:0]   w_pick_len;
  logic [BURST_W-1:0]   w_clamp;
  logic                 w_rinc;
  logic                 w_acc;
  logic [ID_W-1:0]      w_next_ptr;
  logic                 w_tmo;

  // Zero-length requests are never eligible.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_len[i]  = req_len[i*BURST_W +: BURST_W];
    assign w_elig[i] = req[i] & (w_len[i] != '0);
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  assign w_pick_len = w_len[w_pick_idx];
  assign w_clamp    = (w_pick_len > MAXB) ? MAXB : w_pick_len;

  // Pop whenever the burst still owes words, the FIFO has one, and the
  // output register is free or being emptied this cycle.
  assign w_rinc = (r_state == BURST) & (r_rem != '0) & ~rEmpty &
                  (~r_out_valid | out_ready);
  assign w_acc  = r_out_valid & out_ready;

  assign w_next_ptr = (r_out_id == ID_W'(NUM_REQ - 1)) ? '0 : r_out_id + 1'b1;

`ifdef FIFO_RD_BURST_ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_terr;
  logic              w_stall;

  assign w_stall = (r_state == BURST) & (r_rem != '0) & rEmpty;
  assign w_tmo   = w_stall & (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  // Count consecutive empty-stall cycles; any progress restarts the count.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      r_terr <= w_tmo;
      if (w_stall && !w_tmo) r_tcnt <= r_tcnt + 1'b1;
      else                   r_tcnt <= '0;
    end
  end

  assign timeout_err = r_terr;
`else
  assign w_tmo = 1'b0;
`endif

  // Burst FSM with registered grant and output stream.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_ptr       <= '0;
      r_out_id    <= '0;
      r_gnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: begin
          // A word left over from an aborted burst drains before the next
          // grant so its id cannot change under it.
          if (w_acc) r_out_valid <= 1'b0;
          if (w_any && !r_out_valid) begin
            r_state  <= BURST;
            r_gnt    <= w_pick;
            r_out_id <= w_pick_idx;
            r_rem    <= w_clamp;
          end
        end
        BURST: begin
          if (w_rinc) begin
            r_out_data  <= rData;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_rem == BURST_W'(1));
            r_rem       <= r_rem - 1'b1;
          end else if (w_acc) begin
            r_out_valid <= 1'b0;
          end
          if ((w_acc && r_out_last) || w_tmo) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
            r_rem   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rinc      = w_rinc;
  assign gnt       = r_gnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;
  assign busy      = (r_state == BURST);

endmodule
